// File: rtl/uart_rx_int.sv
// 8N1 UART receiver with a single-byte holding register and an interrupt
// level to the CPU. Also reports framing errors (pulse) and overrun (sticky).
module uart_rx_int #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_in,
    input  logic       cpu_end_read,
    output logic       read_int,
    output logic [7:0] uart_read_byte,
    output logic       frame_err,
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [15:0] FULL_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    state_t      state_reg, state_next;
    logic [1:0]  sync_reg;
    logic [15:0] baud_cnt_reg, baud_cnt_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic        armed_reg, armed_next;
    logic [7:0]  shift_reg, shift_next;

    logic        read_int_reg, read_int_next;
    logic [7:0]  byte_reg, byte_next;
    logic        frame_err_reg, frame_err_next;
    logic        overrun_reg, overrun_next;

    logic        rx_sync;
    logic        half_tick;
    logic        full_tick;
    logic        data_sample;
    logic        stop_sample;
    logic        frame_ok;
    logic        frame_bad;

    assign rx_sync   = sync_reg[1];
    assign half_tick = (baud_cnt_reg == HALF_LAST);
    assign full_tick = (baud_cnt_reg == FULL_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], uart_in};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= 16'd0;
            bit_idx_reg  <= 3'd0;
            armed_reg    <= 1'b0;
            shift_reg    <= 8'h00;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            armed_reg    <= armed_next;
            shift_reg    <= shift_next;
        end
    end

    // Next-state logic. armed_reg blocks a new start after a framing error
    // until the line has been seen high again (break handling).
    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_idx_next  = bit_idx_reg;
        armed_next    = armed_reg | rx_sync;
        case (state_reg)
            IDLE: begin
                baud_cnt_next = 16'd0;
                bit_idx_next  = 3'd0;
                if (armed_reg && !rx_sync) begin
                    state_next = START;
                end
            end
            START: begin
                if (half_tick) begin
                    baud_cnt_next = 16'd0;
                    state_next    = rx_sync ? IDLE : DATA;
                end else begin
                    baud_cnt_next = baud_cnt_reg + 16'd1;
                end
            end
            DATA: begin
                if (full_tick) begin
                    baud_cnt_next = 16'd0;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + 16'd1;
                end
            end
            STOP: begin
                if (full_tick) begin
                    baud_cnt_next = 16'd0;
                    state_next    = IDLE;
                    if (!rx_sync) begin
                        armed_next = 1'b0;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign data_sample = (state_reg == DATA) && full_tick;
    assign stop_sample = (state_reg == STOP) && full_tick;
    assign frame_ok    = stop_sample && rx_sync;
    assign frame_bad   = stop_sample && !rx_sync;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_shift
            assign shift_next[gi] = (data_sample && (bit_idx_reg == 3'(gi)))
                                    ? rx_sync : shift_reg[gi];
        end
    endgenerate

    // Output logic: holding register, interrupt level and error flags
    always_comb begin
        read_int_next  = read_int_reg;
        byte_next      = byte_reg;
        overrun_next   = overrun_reg;
        frame_err_next = frame_bad;
        if (cpu_end_read) begin
            read_int_next = 1'b0;
            overrun_next  = 1'b0;
        end
        if (frame_ok) begin
            if (!read_int_reg || cpu_end_read) begin
                byte_next     = shift_reg;
                read_int_next = 1'b1;
            end else begin
                overrun_next  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            read_int_reg  <= 1'b0;
            byte_reg      <= 8'h00;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            read_int_reg  <= read_int_next;
            byte_reg      <= byte_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
        end
    end

    assign read_int       = read_int_reg;
    assign uart_read_byte = byte_reg;
    assign frame_err      = frame_err_reg;
    assign overrun        = overrun_reg;

endmodule
